// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-control bundle between the 5-stage pipeline and the hazard controller.
// master : pipeline side, drives stage control fields and the memory ack,
//          receives buffer enables, flush/bubble strobes, memory request,
//          the error flag and the performance counters.
// slave  : hazard controller side (mirror of master).
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       idRs_i;
    logic [4:0]       idRt_i;
    logic             idUsesRt_i;
    logic             exMemToRead_i;
    logic [4:0]       exWriteAddrReg_i;
    logic             memBranch_i;
    logic             memZf_i;
    logic             memToRead_i;
    logic             memToWrite_i;
    logic             memAck_i;
    logic             pcWrite_o;
    logic             pcSrc_o;
    logic             ifIdWrite_o;
    logic             ifIdFlush_o;
    logic             idExWrite_o;
    logic             idExBubble_o;
    logic             emWrite_o;
    logic             emFlush_o;
    logic             memReq_o;
    logic             memErr_o;
    logic [CNT_W-1:0] stallCnt_o;
    logic [CNT_W-1:0] flushCnt_o;

    modport master (
        output idRs_i, idRt_i, idUsesRt_i, exMemToRead_i, exWriteAddrReg_i,
               memBranch_i, memZf_i, memToRead_i, memToWrite_i, memAck_i,
        input  pcWrite_o, pcSrc_o, ifIdWrite_o, ifIdFlush_o, idExWrite_o,
               idExBubble_o, emWrite_o, emFlush_o, memReq_o, memErr_o,
               stallCnt_o, flushCnt_o
    );

    modport slave (
        input  idRs_i, idRt_i, idUsesRt_i, exMemToRead_i, exWriteAddrReg_i,
               memBranch_i, memZf_i, memToRead_i, memToWrite_i, memAck_i,
        output pcWrite_o, pcSrc_o, ifIdWrite_o, ifIdFlush_o, idExWrite_o,
               idExBubble_o, emWrite_o, emFlush_o, memReq_o, memErr_o,
               stallCnt_o, flushCnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken
// branch flushes (resolved in MEM) and pipe freeze while a multi-cycle data
// memory access is outstanding, with timeout error and perf counters.
// Ports: clk_i, rst_ni (async active-low), hz (slave modport of
//        pipeline_hazard_ctrl_if carrying all stage control and strobes).
//
// state      | meaning
// RUN        | normal flow, hazards evaluated every cycle
// LOAD_STALL | holding extra load-use bubbles (down-counter ls_cnt_q)
// MEM_WAIT   | pipe frozen until memAck_i or MEM_TIMEOUT
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255,
    parameter int CNT_W             = 16
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

    localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);
    localparam logic [1:0] LS_EXTRA = 2'(LOAD_STALL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [1:0]       ls_cnt_q, ls_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic mem_access, branch_taken, load_use, frozen, timeout_hit, flush_inc;
    logic pc_write, pc_src, if_id_write, if_id_flush;
    logic id_ex_write, id_ex_bubble, em_write, em_flush;

    assign mem_access   = hz.memToRead_i | hz.memToWrite_i;
    assign branch_taken = hz.memBranch_i & hz.memZf_i;
    assign load_use     = hz.exMemToRead_i && (hz.exWriteAddrReg_i != 5'd0) &&
                          ((hz.exWriteAddrReg_i == hz.idRs_i) ||
                           (hz.idUsesRt_i && (hz.exWriteAddrReg_i == hz.idRt_i)));
    assign timeout_hit  = (wait_cnt_q == TIMEOUT);
    // Once waiting, the freeze is held by the missing ack alone; the timeout
    // cycle itself already releases the pipe.
    assign frozen = (state_q == MEM_WAIT) ? (!hz.memAck_i && !timeout_hit)
                                          : (mem_access && !hz.memAck_i);

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        ls_cnt_d     = ls_cnt_q;
        err_d        = err_q;
        flush_inc    = 1'b0;
        pc_write     = 1'b1;
        pc_src       = 1'b0;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b0;
        em_write     = 1'b1;
        em_flush     = 1'b0;

        if (frozen) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            em_write    = 1'b0;
            state_d     = MEM_WAIT;
            wait_cnt_d  = (state_q == MEM_WAIT) ? wait_cnt_q + 8'd1 : 8'd1;
        end else begin
            // Release cycle from MEM_WAIT behaves like a RUN cycle.
            if (state_q == MEM_WAIT) begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
                if (!hz.memAck_i) err_d = 1'b1;
            end
            if (branch_taken) begin
                pc_src       = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                em_flush     = 1'b1;
                flush_inc    = 1'b1;
                state_d      = RUN;
            end else if (state_q == LOAD_STALL) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                ls_cnt_d     = ls_cnt_q - 2'd1;
                if (ls_cnt_q <= 2'd1) state_d = RUN;
            end else if (load_use) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                if (LOAD_STALL_CYCLES > 1) begin
                    state_d  = LOAD_STALL;
                    ls_cnt_d = LS_EXTRA;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            ls_cnt_q    <= 2'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ls_cnt_q   <= ls_cnt_d;
            err_q      <= err_d;
            if (!pc_write && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_inc && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign hz.pcWrite_o    = pc_write;
    assign hz.pcSrc_o      = pc_src;
    assign hz.ifIdWrite_o  = if_id_write;
    assign hz.ifIdFlush_o  = if_id_flush;
    assign hz.idExWrite_o  = id_ex_write;
    assign hz.idExBubble_o = id_ex_bubble;
    assign hz.emWrite_o    = em_write;
    assign hz.emFlush_o    = em_flush;
    assign hz.memReq_o     = mem_access;
    assign hz.memErr_o     = err_q;
    assign hz.stallCnt_o   = stall_cnt_q;
    assign hz.flushCnt_o   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: dut_a (1 load-use bubble, timeout 4) and dut_b (2 bubbles,
// timeout 255) share the same stimulus.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [4:0] id_rs, id_rt, ex_wr;
    logic       id_uses_rt, ex_ld, mem_br, mem_zf, mem_rd, mem_wr, mem_ack;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) ia ();
    pipeline_hazard_ctrl_if #(.CNT_W(16)) ib ();

    assign ia.idRs_i = id_rs;            assign ib.idRs_i = id_rs;
    assign ia.idRt_i = id_rt;            assign ib.idRt_i = id_rt;
    assign ia.idUsesRt_i = id_uses_rt;   assign ib.idUsesRt_i = id_uses_rt;
    assign ia.exMemToRead_i = ex_ld;     assign ib.exMemToRead_i = ex_ld;
    assign ia.exWriteAddrReg_i = ex_wr;  assign ib.exWriteAddrReg_i = ex_wr;
    assign ia.memBranch_i = mem_br;      assign ib.memBranch_i = mem_br;
    assign ia.memZf_i = mem_zf;          assign ib.memZf_i = mem_zf;
    assign ia.memToRead_i = mem_rd;      assign ib.memToRead_i = mem_rd;
    assign ia.memToWrite_i = mem_wr;     assign ib.memToWrite_i = mem_wr;
    assign ia.memAck_i = mem_ack;        assign ib.memAck_i = mem_ack;

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(16))
        dut_a (.clk_i(clk), .rst_ni(rst_n), .hz(ia));
    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(255), .CNT_W(16))
        dut_b (.clk_i(clk), .rst_ni(rst_n), .hz(ib));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_wr = 5'd0; id_uses_rt = 1'b0; ex_ld = 1'b0;
        mem_br = 1'b0; mem_zf = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_ack = 1'b0;
    endtask

    // Advance one cycle; returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #2;
        check_eq("rst_pcWrite", ia.pcWrite_o, 1);
        check_eq("rst_emWrite", ia.emWrite_o, 1);
        check_eq("rst_memReq", ia.memReq_o, 0);
        check_eq("rst_pcSrc", ia.pcSrc_o, 0);
        check_eq("rst_stallCnt", ia.stallCnt_o, 0);
        step();
        rst_n = 1'b1;
        step();

        // Load-use via rs.
        ex_ld = 1'b1; ex_wr = 5'd5; id_rs = 5'd5;
        #1;
        check_eq("lu_a_pcWrite", ia.pcWrite_o, 0);
        check_eq("lu_a_ifIdWrite", ia.ifIdWrite_o, 0);
        check_eq("lu_a_bubble", ia.idExBubble_o, 1);
        check_eq("lu_b_pcWrite", ib.pcWrite_o, 0);
        step();
        idle();
        #1;
        check_eq("lu_a_release", ia.pcWrite_o, 1);
        check_eq("lu_b_hold_pc", ib.pcWrite_o, 0);
        check_eq("lu_b_hold_bub", ib.idExBubble_o, 1);
        check_eq("lu_a_stallCnt", ia.stallCnt_o, 1);
        step();
        check_eq("lu_b_release", ib.pcWrite_o, 1);
        check_eq("lu_b_stallCnt", ib.stallCnt_o, 2);

        // $0 never hazards.
        ex_ld = 1'b1; ex_wr = 5'd0; id_rs = 5'd0;
        #1;
        check_eq("r0_pcWrite", ia.pcWrite_o, 1);
        check_eq("r0_bubble", ia.idExBubble_o, 0);
        step();

        // rt path.
        ex_ld = 1'b1; ex_wr = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0;
        #1;
        check_eq("rt_unused_pc", ia.pcWrite_o, 1);
        id_uses_rt = 1'b1;
        #1;
        check_eq("rt_used_pc", ia.pcWrite_o, 0);
        check_eq("rt_used_bub", ia.idExBubble_o, 1);
        step();
        idle();
        #1;
        check_eq("rt_b_hold", ib.pcWrite_o, 0);
        step();
        check_eq("rt_a_stallCnt", ia.stallCnt_o, 2);
        check_eq("rt_b_stallCnt", ib.stallCnt_o, 4);

        // Taken branch together with load-use: branch wins.
        ex_ld = 1'b1; ex_wr = 5'd5; id_rs = 5'd5; mem_br = 1'b1; mem_zf = 1'b1;
        #1;
        check_eq("br_pcSrc", ia.pcSrc_o, 1);
        check_eq("br_pcWrite", ia.pcWrite_o, 1);
        check_eq("br_ifIdWrite", ia.ifIdWrite_o, 1);
        check_eq("br_ifIdFlush", ia.ifIdFlush_o, 1);
        check_eq("br_bubble", ia.idExBubble_o, 1);
        check_eq("br_emFlush", ia.emFlush_o, 1);
        check_eq("br_b_pcWrite", ib.pcWrite_o, 1);
        step();
        idle();
        #1;
        check_eq("br_one_cycle", ia.pcSrc_o, 0);
        check_eq("br_flushCnt", ia.flushCnt_o, 1);
        check_eq("br_stallCnt", ia.stallCnt_o, 2);
        check_eq("br_b_after", ib.pcWrite_o, 1);
        mem_br = 1'b1; mem_zf = 1'b0;
        #1;
        check_eq("nbr_pcSrc", ia.pcSrc_o, 0);
        check_eq("nbr_flush", ia.ifIdFlush_o, 0);
        step();
        check_eq("nbr_flushCnt", ia.flushCnt_o, 1);
        idle();

        // Memory wait: 3 cycles without ack, ack on 4th.
        mem_rd = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("mw_memReq", ia.memReq_o, 1);
            check_eq("mw_pcWrite", ia.pcWrite_o, 0);
            check_eq("mw_emWrite", ia.emWrite_o, 0);
            step();
        end
        mem_ack = 1'b1;
        #1;
        check_eq("mw_ack_pcWrite", ia.pcWrite_o, 1);
        check_eq("mw_ack_memReq", ia.memReq_o, 1);
        step();
        idle();
        #1;
        check_eq("mw_stallCnt", ia.stallCnt_o, 5);
        check_eq("mw_memReq_off", ia.memReq_o, 0);
        check_eq("mw_memErr", ia.memErr_o, 0);

        // Zero-wait access.
        mem_rd = 1'b1; mem_ack = 1'b1;
        #1;
        check_eq("zw_pcWrite", ia.pcWrite_o, 1);
        step();
        idle();
        #1;
        check_eq("zw_stallCnt", ia.stallCnt_o, 5);

        // Timeout on dut_a (4 cycles).
        mem_wr = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("to_frozen", ia.pcWrite_o, 0);
            step();
        end
        #1;
        check_eq("to_release", ia.pcWrite_o, 1);
        check_eq("to_b_frozen", ib.pcWrite_o, 0);
        check_eq("to_err_not_yet", ia.memErr_o, 0);
        step();
        idle();
        mem_ack = 1'b1;
        #1;
        check_eq("to_memErr", ia.memErr_o, 1);
        check_eq("to_a_stallCnt", ia.stallCnt_o, 9);
        step();
        idle();
        step();
        step();
        check_eq("to_sticky", ia.memErr_o, 1);
        check_eq("to_a_run", ia.pcWrite_o, 1);
        check_eq("to_b_memErr", ib.memErr_o, 0);
        check_eq("to_b_stallCnt", ib.stallCnt_o, 12);

        // Reset while in MEM_WAIT.
        mem_rd = 1'b1; mem_ack = 1'b0;
        step();
        step();
        #1;
        check_eq("rw_frozen", ia.pcWrite_o, 0);
        idle();
        rst_n = 1'b0;
        #1;
        check_eq("rw_rst_pcWrite", ia.pcWrite_o, 1);
        check_eq("rw_rst_memErr", ia.memErr_o, 0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("rw_pcWrite", ia.pcWrite_o, 1);
        check_eq("rw_idExWrite", ia.idExWrite_o, 1);
        check_eq("rw_bubble", ia.idExBubble_o, 0);
        check_eq("rw_stallCnt", ia.stallCnt_o, 0);
        check_eq("rw_flushCnt", ia.flushCnt_o, 0);
        check_eq("rw_memErr", ia.memErr_o, 0);
        step();
        check_eq("rw_no_residual", ia.pcWrite_o, 1);
        check_eq("rw_b_no_residual", ib.pcWrite_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
